// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: instruction encodings,
// opcode field position and the fetch-stage state type.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OPC_HALT  = 5'b00000;
  localparam int          OPC_MSB   = 15;
  localparam int          OPC_LSB   = 11;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying instruction, PC+2 and valid between two stages.
// Priority: rst > flush > hold > load; with none of them a bubble is inserted.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                flush,
  input  logic                hold,
  input  logic [15:0]         next_instr,
  input  logic [PC_WIDTH-1:0] next_pc2,
  output logic [15:0]         instr,
  output logic [PC_WIDTH-1:0] pc2,
  output logic                valid
);

  // pc2 is left untouched by flush and bubbles; valid=0 marks it stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= NOP_INSTR;
      pc2   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        instr <= next_instr;
        pc2   <= next_pc2;
        valid <= 1'b1;
      end else begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory, fills IF/ID, and handles stall, redirect, HALT and a fetch counter.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic [15:0]           imem_data,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_en,
  output logic                  imem_wr,
  output logic [15:0]           if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc2,
  output logic                  if_id_valid,
  output logic                  halted,
  output logic                  misalign,
  output logic [15:0]           fetch_count
);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [ADDR_WIDTH-1:0] pc_plus2;
  logic                  misalign_next;
  logic                  ifid_load, ifid_flush, ifid_hold;
  logic                  count_en;

  assign pc_plus2  = pc + ADDR_WIDTH'(2);
  assign imem_addr = pc;
  assign imem_en   = ~rst & (state == RUN) & ~stall;
  assign imem_wr   = 1'b0;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      misalign <= misalign_next;
      if (count_en && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
    end
  end

  // A redirect wins over stall so a speculatively fetched HALT is cancelled.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    misalign_next = 1'b0;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_hold     = 1'b0;
    count_en      = 1'b0;
    if (redirect_valid) begin
      pc_next       = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      state_next    = RUN;
      misalign_next = redirect_pc[0];
      ifid_flush    = 1'b1;
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else begin
      case (state)
        RUN: begin
          ifid_load = 1'b1;
          count_en  = 1'b1;
          if (is_halt(imem_data))
            state_next = HALTED;
          else
            pc_next = pc_plus2;
        end
        HALTED: begin
        end
        default: state_next = RUN;
      endcase
    end
  end

  if_id_reg #(
    .PC_WIDTH(ADDR_WIDTH)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .hold      (ifid_hold),
    .next_instr(imem_data),
    .next_pc2  (pc_plus2),
    .instr     (if_id_instr),
    .pc2       (if_id_pc2),
    .valid     (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle-level reference model pushes
// expected register state; a monitor pops and compares after each edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic        imem_en, imem_wr;
  logic [15:0] if_id_instr, if_id_pc2, fetch_count;
  logic        if_id_valid, halted, misalign;

  logic [15:0] mem [0:32767];

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[15:1]];

  fetch_stage #(
    .ADDR_WIDTH(16),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .imem_wr       (imem_wr),
    .if_id_instr   (if_id_instr),
    .if_id_pc2     (if_id_pc2),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .misalign      (misalign),
    .fetch_count   (fetch_count)
  );

  typedef struct {
    int instr;
    int pc2;
    int pc;
    int count;
    int valid;
    int halted;
    int mis;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state, in plain integers.
  int m_pc = 0, m_instr = 'h0800, m_pc2 = 0, m_valid = 0;
  int m_halted = 0, m_mis = 0, m_count = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit rv, input int rpc, input bit st);
    int   w;
    exp_t e;
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc[15:0];
    stall          = st;
    #1;
    checkOutput("imem_addr", int'(imem_addr), m_pc);
    checkOutput("imem_en", int'(imem_en), int'(!r && m_halted == 0 && !st));
    checkOutput("imem_wr", int'(imem_wr), 0);
    if (r) begin
      m_pc = 0; m_instr = 'h0800; m_pc2 = 0; m_valid = 0;
      m_halted = 0; m_mis = 0; m_count = 0;
    end else if (rv) begin
      m_pc = rpc & 'hFFFE; m_instr = 'h0800; m_valid = 0;
      m_halted = 0; m_mis = rpc & 1;
    end else if (st) begin
      m_mis = 0;
    end else if (m_halted == 0) begin
      w       = int'(mem[m_pc / 2]);
      m_instr = w;
      m_pc2   = (m_pc + 2) % 65536;
      m_valid = 1;
      m_mis   = 0;
      if (m_count < 'hFFFF) m_count++;
      if ((w >> 11) == 0) m_halted = 1;
      else m_pc = (m_pc + 2) % 65536;
    end else begin
      m_instr = 'h0800; m_valid = 0; m_mis = 0;
    end
    e.instr = m_instr; e.pc2 = m_pc2; e.pc = m_pc; e.count = m_count;
    e.valid = m_valid; e.halted = m_halted; e.mis = m_mis;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("if_id_instr", int'(if_id_instr), e.instr);
      checkOutput("if_id_pc2", int'(if_id_pc2), e.pc2);
      checkOutput("if_id_valid", int'(if_id_valid), e.valid);
      checkOutput("pc", int'(imem_addr), e.pc);
      checkOutput("halted", int'(halted), e.halted);
      checkOutput("misalign", int'(misalign), e.mis);
      checkOutput("fetch_count", int'(fetch_count), e.count);
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      if ($urandom_range(0, 39) == 0)
        mem[i] = 16'($urandom_range(0, 2047));
      else
        mem[i] = 16'($urandom_range(16'h0800, 16'hFFFF));
    end
    mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;
    mem[3] = 16'h0000;
    mem[16] = 16'h5001; mem[17] = 16'h5002;
    mem[128] = 16'h6001; mem[129] = 16'h6002;
    mem[32767] = 16'h7FFE;

    // Reset, sequential fetch, stall at 0x0004, then HALT at 0x0006.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);

    // Misaligned redirect out of HALTED.
    applyStimulus(0, 1, 'h0021, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

    // Redirect together with stall must still flush.
    applyStimulus(0, 1, 'h0010, 0);
    applyStimulus(0, 1, 'h0100, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

    // PC wrap from 0xFFFE, then a mid-run reset.
    applyStimulus(0, 1, 'hFFFE, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 11) == 0,
                    int'($urandom_range(0, 65535)),
                    $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
